// File: rtl/wave_synth.sv
// -----------------------------------------------------------------------------
// wave_synth -- phase-accumulator waveform generator.
//
// A free-running phase accumulator (acc) advances by inc_active every enabled
// clock. The top 8 bits of acc form the phase p, which is shaped into saw,
// square, triangle or pulse and registered onto sample.
//
// Increment writes land in a shadow register and are committed only at a
// phase-safe moment (accumulator wrap, an idle cycle, or a phase clear) so
// the running waveform never jumps mid-period.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   en           advance the accumulator this cycle
//   sync_clr     synchronous phase clear (priority over advance)
//   cfg_wr       one-cycle configuration write strobe
//   cfg_addr     0=inc[7:0] 1=inc[15:8] 2=mode[1:0] 3=duty
//   cfg_data     configuration write data
//   sample       registered waveform sample
//   wrap         one-cycle pulse on accumulator overflow
//   inc_pending  shadow increment waiting to be committed
// -----------------------------------------------------------------------------
module wave_synth #(
    parameter int          ACC_W   = 16,
    parameter logic [15:0] DEF_INC = 16'h0100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sync_clr,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic [7:0] sample,
    output logic       wrap,
    output logic       inc_pending
);

    localparam logic [1:0] MODE_SAW   = 2'd0;
    localparam logic [1:0] MODE_SQR   = 2'd1;
    localparam logic [1:0] MODE_TRI   = 2'd2;
    localparam logic [1:0] MODE_PULSE = 2'd3;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      inc_act_q, inc_act_d;
    logic [15:0]      inc_sh_q, inc_sh_d;
    logic             pend_q, pend_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       duty_q, duty_d;
    logic [7:0]       sample_q, sample_d;
    logic             wrap_q, wrap_d;

    logic [ACC_W-1:0] inc_ext;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [7:0]       phase;
    logic [7:0]       wave;
    logic             wr_inc;
    logic             commit;

    // The increment register is 16 bits; fit it to the accumulator width.
    assign inc_ext = ACC_W'(inc_act_q);
    assign sum     = {1'b0, acc_q} + {1'b0, inc_ext};
    assign carry   = sum[ACC_W];
    assign phase   = acc_q[ACC_W-1 -: 8];

    always_comb begin
        wave = 8'h00;
        case (mode_q)
            MODE_SAW:   wave = phase;
            MODE_SQR:   wave = {8{phase[7]}};
            MODE_TRI:   wave = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
            MODE_PULSE: wave = (phase < duty_q) ? 8'hFF : 8'h00;
            default:    wave = 8'h00;
        endcase
    end

    assign wr_inc = cfg_wr && !cfg_addr[1];
    // Commit points are phase-safe: the wrap edge, any idle edge, or a clear.
    // Carry is only meaningful with en=1, but !en already covers the idle case.
    assign commit = pend_q && (sync_clr || !en || carry);

    always_comb begin
        acc_d     = acc_q;
        inc_act_d = inc_act_q;
        inc_sh_d  = inc_sh_q;
        pend_d    = pend_q;
        mode_d    = mode_q;
        duty_d    = duty_q;
        sample_d  = sample_q;
        wrap_d    = 1'b0;

        if (sync_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d  = sum[ACC_W-1:0];
            wrap_d = carry;
        end

        // Sample tracks the pre-edge accumulator, giving one cycle of lag.
        if (en) begin
            sample_d = wave;
        end

        // The committed value is the shadow as it stood before this edge, so a
        // coincident write is kept in the shadow and stays pending.
        if (commit) begin
            inc_act_d = inc_sh_q;
            pend_d    = 1'b0;
        end

        if (cfg_wr) begin
            case (cfg_addr)
                2'd0:    inc_sh_d[7:0]  = cfg_data;
                2'd1:    inc_sh_d[15:8] = cfg_data;
                2'd2:    mode_d         = cfg_data[1:0];
                default: duty_d         = cfg_data;
            endcase
        end
        if (wr_inc) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            inc_act_q <= DEF_INC;
            inc_sh_q  <= DEF_INC;
            pend_q    <= 1'b0;
            mode_q    <= MODE_SAW;
            duty_q    <= 8'h80;
            sample_q  <= 8'h00;
            wrap_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            inc_act_q <= inc_act_d;
            inc_sh_q  <= inc_sh_d;
            pend_q    <= pend_d;
            mode_q    <= mode_d;
            duty_q    <= duty_d;
            sample_q  <= sample_d;
            wrap_q    <= wrap_d;
        end
    end

    assign sample      = sample_q;
    assign wrap        = wrap_q;
    assign inc_pending = pend_q;

endmodule

// File: doc/wave_synth.md
WAVE_SYNTH -- requirements
Module: wave_synth

Interface
REQ-001 Parameter ACC_W, default 16, SHALL set the phase accumulator width (minimum 12).
REQ-002 Parameter DEF_INC, default 16'h0100, SHALL set the phase increment loaded at reset.
REQ-003 Port clk, input, 1: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port en, input, 1: when high, the accumulator advances once per clk.
REQ-006 Port sync_clr, input, 1: synchronous phase clear.
REQ-007 Port cfg_wr, input, 1: one-cycle configuration write strobe.
REQ-008 Port cfg_addr, input, 2: register select (0=inc[7:0], 1=inc[15:8], 2=mode[1:0], 3=duty).
REQ-009 Port cfg_data, input, 8: configuration write data.
REQ-010 Port sample, output, 8: registered waveform sample that feeds the chip output stage.
REQ-011 Port wrap, output, 1: one-cycle pulse on accumulator overflow.
REQ-012 Port inc_pending, output, 1: high while a shadow increment awaits commit.

Function
REQ-013 The phase p SHALL be acc[ACC_W-1:ACC_W-8].
REQ-014 With en=1, the accumulator SHALL compute acc <= acc + inc_active modulo 2^ACC_W, and the carry-out SHALL drive wrap high on the following cycle.
REQ-015 With en=0, acc, sample and wrap SHALL hold, except that wrap SHALL be 0.
REQ-016 sync_clr=1 SHALL set acc to 0 on the next edge regardless of en, SHALL take priority over increment, and SHALL NOT assert wrap.
REQ-017 Writes to addresses 0 and 1 SHALL update inc_shadow and set inc_pending=1.
REQ-018 inc_pending SHALL commit (inc_active <= inc_shadow, inc_pending <= 0) on the first of: the edge on which acc wraps, an edge with en=0, or an edge with sync_clr=1.
REQ-019 A write to address 0 or 1 coincident with a commit edge SHALL land in inc_shadow, SHALL leave inc_pending=1, and SHALL NOT be lost.
REQ-020 Writes to addresses 2 and 3 SHALL take effect on the next edge; mode SHALL use cfg_data[1:0].
REQ-021 mode 0 (saw): sample = p.
REQ-022 mode 1 (square): sample = 8'hFF if p[7] is set, else 8'h00.
REQ-023 mode 2 (triangle): sample = {p[6:0],1'b0} if p[7]=0, else ~{p[6:0],1'b0}.
REQ-024 mode 3 (pulse): sample = 8'hFF if p < duty, else 8'h00; duty=0 SHALL give a constant 00.
REQ-025 sample SHALL be registered from the current acc, giving exactly 1 cycle of latency from an acc change to the sample change.
REQ-026 inc_active=0 SHALL freeze the phase without asserting wrap.

Reset
REQ-027 While rst=1, the block SHALL hold acc=0, inc_active=inc_shadow=DEF_INC, mode=0, duty=8'h80, sample=8'h00, wrap=0 and inc_pending=0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard any pending increment; the first advance after release SHALL occur on the first edge with rst=0 and en=1.

Verification
REQ-029 Saw test: after reset, en=1 held -> sample reads 00,00,01,02,...,FF,00, and wrap pulses once every 256 cycles, aligned with acc=0.
REQ-030 Square/triangle test: mode=1, inc=0x0800 -> 16 samples of 00 then 16 of FF, repeating; mode=2, inc=0x0100 -> 00,02,...,FE,FF,FD,...,01.
REQ-031 Pulse test: mode=3, duty=0x40, inc=0x0100 -> FF for 64 cycles, then 00 for 192 cycles; duty=0x00 -> constant 00.
REQ-032 Phase-continuous update: with a saw running at inc=0x0100, writing inc=0x0200 at acc=0x3000 -> inc_pending=1 and the step stays 1 until wrap, then the step becomes 2 and inc_pending=0.
REQ-033 Control test: sync_clr with en=1 at acc=0x8000 -> acc=0, no wrap, sample=00 one cycle later; en=0 for 10 cycles -> sample constant and wrap=0.
REQ-034 Reset test: assert rst mid-cycle at acc=0x5A00 with a write pending -> all outputs reach their reset values immediately; after release, inc=0x0100 and the saw restarts at 00.
